// File: rtl/multi_hit_encoder.sv
// rtl/multi_hit_encoder.sv - streams the index of every set bit of an accepted vector, one beat per transfer
module multi_hit_encoder #(
    parameter int N         = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         encoder_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] binary_out,
    output logic                 out_last,
    output logic                 out_zero
);

    localparam int W = $clog2(N);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t         state;
    logic [N-1:0]   pending;
    logic           zero_flag;
    logic [W-1:0]   scan_idx;
    logic           multi_hit;
    logic           accept;
    logic           transfer;

    // Later loop iterations override earlier ones, so iterate towards the preferred end.
    always_comb begin
        scan_idx = '0;
        if (LSB_FIRST) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pending[i]) scan_idx = i[W-1:0];
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pending[i]) scan_idx = i[W-1:0];
            end
        end
    end

    assign multi_hit  = |(pending & (pending - ONE));

    assign in_ready   = enable && (state == IDLE);
    assign out_valid  = enable && (state == SCAN);
    assign binary_out = scan_idx;
    assign out_last   = (state == SCAN) && !multi_hit;
    assign out_zero   = (state == SCAN) && zero_flag;

    assign accept     = in_valid && in_ready;
    assign transfer   = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= '0;
            zero_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pending   <= encoder_in;
                        zero_flag <= ~|encoder_in;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (transfer) begin
                        // An all-zero vector clears nothing here; its single beat is already last.
                        pending <= pending & ~(ONE << scan_idx);
                        if (out_last) begin
                            state     <= IDLE;
                            zero_flag <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_hit_encoder.sv
// tb/tb_multi_hit_encoder.sv - self-checking bench for multi_hit_encoder in both scan orders
module tb_multi_hit_encoder;

    localparam int N = 16;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic           in_valid;
    logic           out_ready;
    logic [N-1:0]   encoder_in;

    logic [1:0]     in_ready;
    logic [1:0]     out_valid;
    logic [1:0]     out_last;
    logic [1:0]     out_zero;
    logic [W-1:0]   bin_l;
    logic [W-1:0]   bin_m;

    int checks = 0;
    int errors = 0;

    // Reference model: the full ordered list of beats still owed, per scan order.
    int mq_l[$];
    int mq_m[$];
    bit m_zero;

    // Observed transfers encoded as idx + 100*last + 1000*zero.
    int log_l[$];
    int log_m[$];

    always #5 clk = ~clk;

    multi_hit_encoder #(.N(N), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready[0]), .encoder_in(encoder_in),
        .out_valid(out_valid[0]), .out_ready(out_ready), .binary_out(bin_l),
        .out_last(out_last[0]), .out_zero(out_zero[0])
    );

    multi_hit_encoder #(.N(N), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready[1]), .encoder_in(encoder_in),
        .out_valid(out_valid[1]), .out_ready(out_ready), .binary_out(bin_m),
        .out_last(out_last[1]), .out_zero(out_zero[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq_l.delete();
            mq_m.delete();
            m_zero <= 1'b0;
        end else if (enable) begin
            if (mq_l.size() == 0 && in_valid) begin
                if (encoder_in == '0) begin
                    mq_l.push_back(0);
                    mq_m.push_back(0);
                    m_zero <= 1'b1;
                end else begin
                    m_zero <= 1'b0;
                    for (int i = 0; i < N; i++) begin
                        if (encoder_in[i]) begin
                            mq_l.push_back(i);
                            mq_m.push_front(i);
                        end
                    end
                end
            end else if (mq_l.size() != 0 && out_ready) begin
                void'(mq_l.pop_front());
                void'(mq_m.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready_l", int'(in_ready[0]), int'(enable && mq_l.size() == 0));
            chk("in_ready_m", int'(in_ready[1]), int'(enable && mq_m.size() == 0));
            chk("out_valid_l", int'(out_valid[0]), int'(enable && mq_l.size() != 0));
            chk("out_valid_m", int'(out_valid[1]), int'(enable && mq_m.size() != 0));
            if (enable && mq_l.size() != 0) begin
                chk("binary_out_l", int'(bin_l), mq_l[0]);
                chk("binary_out_m", int'(bin_m), mq_m[0]);
                chk("out_last_l", int'(out_last[0]), int'(mq_l.size() == 1));
                chk("out_last_m", int'(out_last[1]), int'(mq_m.size() == 1));
                chk("out_zero_l", int'(out_zero[0]), int'(m_zero));
                chk("out_zero_m", int'(out_zero[1]), int'(m_zero));
            end
            if (enable && out_ready && out_valid[0])
                log_l.push_back(int'(bin_l) + 100 * int'(out_last[0]) + 1000 * int'(out_zero[0]));
            if (enable && out_ready && out_valid[1])
                log_m.push_back(int'(bin_m) + 100 * int'(out_last[1]) + 1000 * int'(out_zero[1]));
        end
    end

    task automatic send(input logic [N-1:0] v);
        @(posedge clk); #1;
        in_valid   = 1'b1;
        encoder_in = v;
        @(posedge clk); #1;
        in_valid   = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (mq_l.size() != 0 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("drain_timeout", mq_l.size(), 0);
    endtask

    task automatic chk_log(input string nm, input int n, input int el[5], input int em[5]);
        chk({nm, "_beats_l"}, log_l.size(), n);
        chk({nm, "_beats_m"}, log_m.size(), n);
        for (int i = 0; i < n; i++) begin
            chk({nm, "_beat_l"}, (i < log_l.size()) ? log_l[i] : -1, el[i]);
            chk({nm, "_beat_m"}, (i < log_m.size()) ? log_m[i] : -1, em[i]);
        end
        log_l.delete();
        log_m.delete();
    endtask

    initial begin
        int c;
        reset      = 1'b1;
        enable     = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        encoder_in = '0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_zero", int'(out_zero), 0);
        chk("rst_bin_l", int'(bin_l), 0);
        chk("rst_bin_m", int'(bin_m), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 3);

        send(16'h0004);
        drain();
        chk_log("v0004", 1, '{102, 0, 0, 0, 0}, '{102, 0, 0, 0, 0});

        send(16'h4040);
        drain();
        chk_log("v4040", 2, '{6, 114, 0, 0, 0}, '{14, 106, 0, 0, 0});

        send(16'h0000);
        drain();
        chk_log("v0000", 1, '{1100, 0, 0, 0, 0}, '{1100, 0, 0, 0, 0});

        out_ready = 1'b0;
        send(16'h8001);
        repeat (3) begin
            @(negedge clk);
            chk("stall_bin_l", int'(bin_l), 0);
            chk("stall_bin_m", int'(bin_m), 15);
            chk("stall_valid", int'(out_valid), 3);
        end
        @(posedge clk); #1 enable = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("frozen_valid", int'(out_valid), 0);
            chk("frozen_ready", int'(in_ready), 0);
        end
        @(posedge clk); #1;
        enable    = 1'b1;
        out_ready = 1'b1;
        drain();
        chk_log("v8001", 2, '{0, 115, 0, 0, 0}, '{15, 100, 0, 0, 0});

        send(16'hFFFF);
        c = 0;
        while (log_l.size() < 5 && c < 50) begin
            @(posedge clk);
            c++;
        end
        chk("five_beats_timeout", int'(log_l.size() >= 5), 1);
        #2 reset = 1'b1;
        #1;
        chk("midscan_rst_valid", int'(out_valid), 0);
        chk("midscan_rst_last", int'(out_last), 0);
        chk("midscan_rst_bin_m", int'(bin_m), 0);
        chk_log("vFFFF", 5, '{0, 1, 2, 3, 4}, '{15, 14, 13, 12, 11});
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rerst_in_ready", int'(in_ready), 3);

        send(16'h0400);
        drain();
        chk_log("v0400", 1, '{110, 0, 0, 0, 0}, '{110, 0, 0, 0, 0});

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
